fsu_linear_seq: RTL and testbench



---
 rtl/fsu_linear_seq.sv | 155 +++++++++++++++
 tb/tb_fsu_linear_seq.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsu_linear_seq.sv
// Control sequencer for one stochastic-computing linear layer pass: load, partitioned streaming, drain, and a result handshake.
// Optional build macro HOLD_EN adds a registered hold input that freezes streaming and draining.
module fsu_linear_seq #(
  parameter int RWID = 10,
  parameter int FOLD = 1,
  parameter int PWID = ($clog2(FOLD) < 2) ? 1 : $clog2(FOLD),
  parameter int LAT  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            ready,
  output logic            load,
  output logic            sel,
  output logic            clear,
  output logic [PWID-1:0] part,
  output logic            run,
  output logic [RWID-1:0] cnt,
`ifdef HOLD_EN
  input  logic            hold,
  output logic            oHold,
`endif
  output logic            oValid,
  input  logic            oReady
);

  localparam int DWID = ($clog2(LAT + 1) < 1) ? 1 : $clog2(LAT + 1);
  localparam logic [DWID-1:0] DRAIN_LAST = (LAT == 0) ? '0 : DWID'(LAT - 1);
  localparam logic [PWID-1:0] PART_LAST  = PWID'(FOLD - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t          r_state;
  state_t          w_stateNext;
  logic            r_sel;
  logic            w_selNext;
  logic [PWID-1:0] r_part;
  logic [PWID-1:0] w_partNext;
  logic [RWID-1:0] r_cnt;
  logic [RWID-1:0] w_cntNext;
  logic [DWID-1:0] r_drain;
  logic [DWID-1:0] w_drainNext;
  logic            w_hold;
  logic            w_lastCycle;
  logic            w_lastPart;

`ifdef HOLD_EN
  // Hold is registered so no input reaches an output combinationally.
  logic r_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold <= 1'b0;
    end else begin
      r_hold <= hold;
    end
  end

  assign w_hold = r_hold;
  assign oHold  = r_hold;
`else
  assign w_hold = 1'b0;
`endif

  assign w_lastCycle = &r_cnt;
  assign w_lastPart  = (r_part == PART_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sel   <= 1'b0;
      r_part  <= '0;
      r_cnt   <= '0;
      r_drain <= '0;
    end else begin
      r_state <= w_stateNext;
      r_sel   <= w_selNext;
      r_part  <= w_partNext;
      r_cnt   <= w_cntNext;
      r_drain <= w_drainNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_selNext   = r_sel;
    w_partNext  = r_part;
    w_cntNext   = r_cnt;
    w_drainNext = r_drain;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_stateNext = LOAD;
        end
      end
      LOAD: begin
        w_partNext  = '0;
        w_cntNext   = '0;
        w_drainNext = '0;
        w_selNext   = ~r_sel;
        w_stateNext = RUN;
      end
      RUN: begin
        if (!w_hold) begin
          w_cntNext = r_cnt + 1'b1;
          if (w_lastCycle) begin
            // Part stays at its last value through drain so result buffers index correctly.
            if (w_lastPart) begin
              if (LAT == 0) begin
                w_stateNext = DONE;
              end else begin
                w_stateNext = DRAIN;
              end
            end else begin
              w_partNext = r_part + 1'b1;
            end
          end
        end
      end
      DRAIN: begin
        if (!w_hold) begin
          if (r_drain == DRAIN_LAST) begin
            w_stateNext = DONE;
          end else begin
            w_drainNext = r_drain + 1'b1;
          end
        end
      end
      DONE: begin
        if (oReady) begin
          w_stateNext = IDLE;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  assign ready  = (r_state == IDLE);
  assign load   = (r_state == LOAD);
  assign run    = (r_state == RUN) && !w_hold;
  assign clear  = run && (r_cnt == '0);
  assign oValid = (r_state == DONE);
  assign sel    = r_sel;
  assign part   = r_part;
  assign cnt    = r_cnt;

endmodule

// File: tb/tb_fsu_linear_seq.sv
// Scoreboard bench for fsu_linear_seq: two configurations (RWID=3/FOLD=2/LAT=2 and RWID=2/FOLD=3/LAT=0).
module tb_fsu_linear_seq;

  localparam int K_LOAD  = 0;
  localparam int K_CLEAR = 1;
  localparam int K_VALID = 2;

  typedef struct {
    int kind;
    int cyc;
    int part;
    int sel;
    int runs;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       startA, oReadyA, startB, oReadyB;
  logic       readyA, loadA, selA, clearA, runA, oValidA;
  logic [0:0] partA;
  logic [2:0] cntA;
  logic       readyB, loadB, selB, clearB, runB, oValidB;
  logic [1:0] partB;
  logic [1:0] cntB;
`ifdef HOLD_EN
  logic       oHoldA, oHoldB;
`endif

  ev_t qA[$];
  ev_t qB[$];
  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  int  runCntA = 0;
  int  runCntB = 0;
  logic prevValidA = 1'b0;
  logic prevValidB = 1'b0;

  fsu_linear_seq #(.RWID(3), .FOLD(2), .LAT(2)) dutA (
    .clk(clk), .rst(rst), .start(startA), .ready(readyA), .load(loadA),
    .sel(selA), .clear(clearA), .part(partA), .run(runA), .cnt(cntA),
`ifdef HOLD_EN
    .hold(1'b0), .oHold(oHoldA),
`endif
    .oValid(oValidA), .oReady(oReadyA)
  );

  fsu_linear_seq #(.RWID(2), .FOLD(3), .LAT(0)) dutB (
    .clk(clk), .rst(rst), .start(startB), .ready(readyB), .load(loadB),
    .sel(selB), .clear(clearB), .part(partB), .run(runB), .cnt(cntB),
`ifdef HOLD_EN
    .hold(1'b0), .oHold(oHoldB),
`endif
    .oValid(oValidB), .oReady(oReadyB)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input int kind);
    tests++;
    fails++;
    $display("[TB] FAIL %s: unexpected event kind %0d at cycle %0d, expected none", name, kind, cyc);
  endtask

  task automatic checkEvent(input string tag, input ev_t e, input int kind, input int p, input int s, input int r);
    checkOutput({tag, ".kind"}, kind, e.kind);
    checkOutput({tag, ".cycle"}, cyc, e.cyc);
    if (e.part >= 0) checkOutput({tag, ".part"}, p, e.part);
    if (e.sel >= 0) checkOutput({tag, ".sel"}, s, e.sel);
    if (e.runs >= 0) checkOutput({tag, ".runCycles"}, r, e.runs);
  endtask

  task automatic popA(input int kind, input int p, input int s, input int r);
    ev_t e;
    if (qA.size() == 0) begin
      unexpected("A.event", kind);
    end else begin
      e = qA.pop_front();
      checkEvent("A", e, kind, p, s, r);
    end
  endtask

  task automatic popB(input int kind, input int p, input int s, input int r);
    ev_t e;
    if (qB.size() == 0) begin
      unexpected("B.event", kind);
    end else begin
      e = qB.pop_front();
      checkEvent("B", e, kind, p, s, r);
    end
  endtask

  // Monitors: turn load pulses, clear pulses and oValid rising edges into scoreboard events.
  always @(negedge clk) begin
    if (rst) begin
      prevValidA = 1'b0;
      runCntA    = 0;
    end else begin
      if (runA) runCntA++;
      if (loadA) begin
        runCntA = 0;
        popA(K_LOAD, int'(partA), int'(selA), runCntA);
      end
      if (clearA) begin
        checkOutput("A.clearCnt", int'(cntA), 0);
        popA(K_CLEAR, int'(partA), int'(selA), runCntA);
      end
      if (oValidA && !prevValidA) popA(K_VALID, int'(partA), int'(selA), runCntA);
      prevValidA = oValidA;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      prevValidB = 1'b0;
      runCntB    = 0;
    end else begin
      if (runB) runCntB++;
      if (loadB) begin
        runCntB = 0;
        popB(K_LOAD, int'(partB), int'(selB), runCntB);
      end
      if (clearB) begin
        checkOutput("B.clearCnt", int'(cntB), 0);
        popB(K_CLEAR, int'(partB), int'(selB), runCntB);
      end
      if (oValidB && !prevValidB) popB(K_VALID, int'(partB), int'(selB), runCntB);
      prevValidB = oValidB;
    end
  end

  function automatic ev_t mk(input int kind, input int c, input int p, input int s, input int r);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.part = p;
    e.sel  = s;
    e.runs = r;
    return e;
  endfunction

  // Config A: load at +1, clears at +2/+10, oValid at +20 after 16 run cycles.
  task automatic pushPassA(input int base, input int s);
    qA.push_back(mk(K_LOAD, base + 1, -1, -1, -1));
    qA.push_back(mk(K_CLEAR, base + 2, 0, s, -1));
    qA.push_back(mk(K_CLEAR, base + 10, 1, s, -1));
    qA.push_back(mk(K_VALID, base + 20, 1, s, 16));
  endtask

  // Config B: partitions of 4 cycles, oValid straight after the last run cycle.
  task automatic pushPassB(input int base, input int s);
    qB.push_back(mk(K_LOAD, base + 1, -1, -1, -1));
    qB.push_back(mk(K_CLEAR, base + 2, 0, s, -1));
    qB.push_back(mk(K_CLEAR, base + 6, 1, s, -1));
    qB.push_back(mk(K_CLEAR, base + 10, 2, s, -1));
    qB.push_back(mk(K_VALID, base + 14, 2, s, 12));
  endtask

  task automatic applyStimulusA(input logic keepHigh, output int base);
    @(negedge clk);
    startA = 1'b1;
    @(posedge clk);
    #1;
    base = cyc - 1;
    if (!keepHigh) begin
      @(negedge clk);
      startA = 1'b0;
    end
  endtask

  task automatic applyStimulusB(output int base);
    @(negedge clk);
    startB = 1'b1;
    @(posedge clk);
    #1;
    base = cyc - 1;
    @(negedge clk);
    startB = 1'b0;
  endtask

  task automatic waitEmptyA(input int budget, input string name);
    int n = 0;
    while (qA.size() != 0 && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (qA.size() != 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s: %0d events still pending, required 0", name, qA.size());
      qA.delete();
    end
  endtask

  task automatic waitEmptyB(input int budget, input string name);
    int n = 0;
    while (qB.size() != 0 && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (qB.size() != 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s: %0d events still pending, required 0", name, qB.size());
      qB.delete();
    end
  endtask

  task automatic checkResetA(input string tag);
    checkOutput({tag, ".ready"}, int'(readyA), 1);
    checkOutput({tag, ".load"}, int'(loadA), 0);
    checkOutput({tag, ".run"}, int'(runA), 0);
    checkOutput({tag, ".clear"}, int'(clearA), 0);
    checkOutput({tag, ".oValid"}, int'(oValidA), 0);
    checkOutput({tag, ".sel"}, int'(selA), 0);
    checkOutput({tag, ".part"}, int'(partA), 0);
    checkOutput({tag, ".cnt"}, int'(cntA), 0);
  endtask

  initial begin
    int base;
    int n;
    rst     = 1'b1;
    startA  = 1'b0;
    startB  = 1'b0;
    oReadyA = 1'b0;
    oReadyB = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetA("A.reset");
    checkOutput("B.reset.ready", int'(readyB), 1);
    checkOutput("B.reset.oValid", int'(oValidB), 0);
    checkOutput("B.reset.part", int'(partB), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Single pass with oReady low: result must be held while downstream stalls.
    applyStimulusA(1'b0, base);
    pushPassA(base, 1);
    waitEmptyA(40, "A.pass1");
    for (int i = 0; i < 5; i++) begin
      startA = 1'b1;
      checkOutput("A.stall.oValid", int'(oValidA), 1);
      checkOutput("A.stall.ready", int'(readyA), 0);
      @(posedge clk);
      #2;
    end
    startA  = 1'b0;
    oReadyA = 1'b1;
    @(posedge clk);
    #2;
    checkOutput("A.release.ready", int'(readyA), 1);
    checkOutput("A.release.oValid", int'(oValidA), 0);
    repeat (3) @(posedge clk);

    // Back-to-back passes with start held high.
    applyStimulusA(1'b1, base);
    pushPassA(base, 0);
    pushPassA(base + 21, 1);
    waitEmptyA(70, "A.backToBack");
    startA = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    checkOutput("A.b2b.idleReady", int'(readyA), 1);

    // Reset while streaming at cnt=5, then a clean pass.
    applyStimulusA(1'b0, base);
    qA.push_back(mk(K_LOAD, base + 1, -1, -1, -1));
    qA.push_back(mk(K_CLEAR, base + 2, 0, 0, -1));
    n = 0;
    while (!(runA && cntA == 3'd5) && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("A.reachCnt5", int'(cntA), 5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkResetA("A.midReset");
    checkOutput("A.midReset.pending", qA.size(), 0);
    qA.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    applyStimulusA(1'b0, base);
    pushPassA(base, 1);
    waitEmptyA(40, "A.afterReset");

    // Config B: FOLD=3, LAT=0.
    oReadyB = 1'b1;
    applyStimulusB(base);
    pushPassB(base, 1);
    waitEmptyB(40, "B.pass");
    repeat (3) @(posedge clk);
    #2;
    checkOutput("B.idleReady", int'(readyB), 1);
    checkOutput("B.idlePart", int'(partB), 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
